ext_memory_responder: RTL and testbench

//  Memory-side responder for the external bus driven by the CPU memory controller. Decodes ExternalDrive
//  (fetch/read/write), serves word accesses from an internal array after programmable wait states, and

---
 rtl/mem_resp_pkg.sv | 29 ++
 rtl/ext_mem_array.sv | 29 ++
 rtl/ext_memory_responder.sv | 140 ++++++++++++++
 tb/tb_ext_memory_responder.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// Shared encodings for the external-bus memory responder: bus commands, FSM states and fault data.
// Also provides small helpers that classify bus commands.
package mem_resp_pkg;

  localparam logic [2:0] CMD_NOP   = 3'b000;
  localparam logic [2:0] CMD_FETCH = 3'b001;
  localparam logic [2:0] CMD_READ  = 3'b010;
  localparam logic [2:0] CMD_WRITE = 3'b011;
  localparam logic [2:0] CMD_IO_RD = 3'b100;
  localparam logic [2:0] CMD_IO_WR = 3'b101;

  localparam logic [31:0] FAULT_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  function automatic logic is_mem_cmd(input logic [2:0] cmd);
    return (cmd == CMD_FETCH) || (cmd == CMD_READ) || (cmd == CMD_WRITE);
  endfunction

  // Commands that return data to the CPU, so the responder owns the data bus in ACK.
  function automatic logic is_read_like(input logic [2:0] cmd);
    return (cmd != CMD_NOP) && (cmd != CMD_WRITE) && (cmd != CMD_IO_WR);
  endfunction

endpackage

// File: rtl/ext_mem_array.sv
// Single-port synchronous 32-bit RAM backing the external bus responder.
// Write has priority over read; read data is registered and holds until the next read.
module ext_mem_array #(
  parameter int    ADDR_BITS = 10,
  parameter string INIT_FILE = ""
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic                 re,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata
);

  logic [31:0] mem [2**ADDR_BITS];

  initial begin
    for (int i = 0; i < 2**ADDR_BITS; i++) mem[i] = '0;
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/ext_memory_responder.sv
// Memory-side responder for the CPU external bus: decodes fetch/read/write, inserts wait states,
// serves words from ext_mem_array. Optional MEM_RESP_FAULT_EN adds BusFault for bad addresses/commands.
module ext_memory_responder
  import mem_resp_pkg::*;
#(
  parameter int    ADDR_BITS   = 10,
  parameter int    WAIT_STATES = 2,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  ExternalDrive,
  input  logic [31:0] ExternalAddressBus,
  inout  wire  [31:0] ExternalDataBus,
  output logic        ExternalExchangeReady
`ifdef MEM_RESP_FAULT_EN
  ,
  output logic        BusFault
`endif
);

  localparam bit         ZERO_WAIT = (WAIT_STATES == 0);
  localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES - 1);

  state_t         state;
  logic [2:0]     cmd_q;
  logic [31:0]    addr_q;
  logic [3:0]     wait_cnt;
  logic           fault_q;
  logic           drive_en;

  logic           accept;
  logic           cmd_fault;
  logic           access;
  logic [2:0]     access_cmd;
  logic           access_fault;
  logic [ADDR_BITS-1:0] access_addr;
  logic           mem_we;
  logic           mem_re;
  logic [31:0]    mem_rdata;

`ifdef MEM_RESP_FAULT_EN
  // Any non-NOP code is taken; reserved codes and out-of-range addresses complete as faults.
  assign accept    = (ExternalDrive != CMD_NOP);
  assign cmd_fault = !is_mem_cmd(ExternalDrive) || (|ExternalAddressBus[31:ADDR_BITS]);
  assign BusFault  = fault_q && ExternalExchangeReady;
`else
  assign accept    = is_mem_cmd(ExternalDrive);
  assign cmd_fault = 1'b0;
`endif

  // With zero wait states the array is accessed on the capture edge, straight from the bus.
  always_comb begin
    access_cmd   = (state == ST_IDLE) ? ExternalDrive : cmd_q;
    access_fault = (state == ST_IDLE) ? cmd_fault : fault_q;
    access_addr  = (state == ST_IDLE) ? ExternalAddressBus[ADDR_BITS-1:0]
                                      : addr_q[ADDR_BITS-1:0];
    if (ZERO_WAIT) begin
      access = (state == ST_IDLE) && accept;
    end else begin
      access = (state == ST_WAIT) && (ExternalDrive == cmd_q) && (wait_cnt == WAIT_LAST);
    end
    mem_we = access && !access_fault && (access_cmd == CMD_WRITE);
    mem_re = access && !access_fault &&
             ((access_cmd == CMD_FETCH) || (access_cmd == CMD_READ));
  end

  ext_mem_array #(
    .ADDR_BITS(ADDR_BITS),
    .INIT_FILE(INIT_FILE)
  ) u_array (
    .clk  (clk),
    .we   (mem_we),
    .re   (mem_re),
    .addr (access_addr),
    .wdata(ExternalDataBus),
    .rdata(mem_rdata)
  );

  // Transaction FSM: capture in IDLE, count wait states, then hold ACK while the CPU keeps the request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state                 <= ST_IDLE;
      cmd_q                 <= CMD_NOP;
      addr_q                <= '0;
      wait_cnt              <= '0;
      fault_q               <= 1'b0;
      drive_en              <= 1'b0;
      ExternalExchangeReady <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            cmd_q    <= ExternalDrive;
            addr_q   <= ExternalAddressBus;
            fault_q  <= cmd_fault;
            wait_cnt <= '0;
            if (ZERO_WAIT) begin
              state                 <= ST_ACK;
              ExternalExchangeReady <= 1'b1;
              drive_en              <= is_read_like(ExternalDrive);
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (ExternalDrive != cmd_q) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            fault_q  <= 1'b0;
          end else if (wait_cnt == WAIT_LAST) begin
            state                 <= ST_ACK;
            wait_cnt              <= '0;
            ExternalExchangeReady <= 1'b1;
            drive_en              <= is_read_like(cmd_q);
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        ST_ACK: begin
          if ((ExternalDrive != cmd_q) || (ExternalAddressBus != addr_q)) begin
            state                 <= ST_IDLE;
            fault_q               <= 1'b0;
            drive_en              <= 1'b0;
            ExternalExchangeReady <= 1'b0;
          end
        end
        default: begin
          state                 <= ST_IDLE;
          drive_en              <= 1'b0;
          ExternalExchangeReady <= 1'b0;
        end
      endcase
    end
  end

  assign ExternalDataBus = drive_en ? (fault_q ? FAULT_DATA : mem_rdata) : 'z;

endmodule

// File: tb/tb_ext_memory_responder.sv
// Randomized self-checking bench for ext_memory_responder against a word-array reference model.
// Builds with or without MEM_RESP_FAULT_EN.
module tb_ext_memory_responder;
  import mem_resp_pkg::*;

  localparam int WS    = 2;
  localparam int AB    = 10;
  localparam int DEPTH = 1 << AB;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  drive;
  logic [31:0] addr;
  wire  [31:0] bus;
  logic        tb_drive;
  logic [31:0] tb_data;
  logic        ready;
`ifdef MEM_RESP_FAULT_EN
  logic        bus_fault;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] ref_mem [int];

  assign bus = tb_drive ? tb_data : 'z;

  always #5 clk = ~clk;

  ext_memory_responder #(
    .ADDR_BITS(AB),
    .WAIT_STATES(WS),
    .INIT_FILE("")
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .ExternalDrive        (drive),
    .ExternalAddressBus   (addr),
    .ExternalDataBus      (bus),
    .ExternalExchangeReady(ready)
`ifdef MEM_RESP_FAULT_EN
    ,
    .BusFault             (bus_fault)
`endif
  );

  function automatic int idx(input logic [31:0] a);
    return int'(a % DEPTH);
  endfunction

  // Present a command at a falling edge and wait (bounded) for Ready; returns edges taken and bus value.
  task automatic run_cmd(input logic [2:0] c, input logic [31:0] a, input logic [31:0] d,
                         output int cycles, output logic [31:0] val);
    @(negedge clk);
    drive    = c;
    addr     = a;
    tb_drive = (c == CMD_WRITE);
    tb_data  = (c == CMD_WRITE) ? d : 32'h0;
    cycles   = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      cycles++;
    end while (!ready && cycles < 40);
    val = bus;
  endtask

  // Drop the command; the bench parks 0 on the bus so a released bus reads back 0.
  task automatic end_cmd();
    drive    = CMD_NOP;
    tb_drive = 1'b1;
    tb_data  = 32'h0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    int cyc;
    logic [31:0] v;
    run_cmd(CMD_WRITE, a, d, cyc, v);
    end_cmd();
    ref_mem[idx(a)] = d;
  endtask

  task automatic test_reset();
    rst = 1'b1; drive = CMD_NOP; addr = '0; tb_drive = 1'b1; tb_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 0", ready); end
    checks++;
    if (bus !== 32'h0) begin errors++; $display("[TB] FAIL reset_bus: got %h expected 00000000", bus); end
`ifdef MEM_RESP_FAULT_EN
    checks++;
    if (bus_fault !== 1'b0) begin errors++; $display("[TB] FAIL reset_fault: got %b expected 0", bus_fault); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_fetch();
    int cyc;
    logic [31:0] v, d;
    d = $urandom | 32'h1;
    do_write(32'd4, d);
    run_cmd(CMD_FETCH, 32'd4, 32'h0, cyc, v);
    checks++;
    if (cyc != WS + 1) begin errors++; $display("[TB] FAIL fetch_latency: got %0d expected %0d", cyc, WS + 1); end
    checks++;
    if (v !== ref_mem[4]) begin errors++; $display("[TB] FAIL fetch_data: got %h expected %h", v, ref_mem[4]); end
    end_cmd();
    checks++;
    if (ready !== 1'b0) begin errors++; $display("[TB] FAIL fetch_drop_ready: got %b expected 0", ready); end
    checks++;
    if (bus !== 32'h0) begin errors++; $display("[TB] FAIL fetch_drop_bus: got %h expected 00000000", bus); end
  endtask

  task automatic test_write_read();
    int cyc;
    logic [31:0] a, d, v;
    logic [2:0] c;
    for (int i = 0; i < 8; i++) begin
      a = (i == 5) ? a : $urandom_range(0, DEPTH - 1);
      d = $urandom;
      run_cmd(CMD_WRITE, a, d, cyc, v);
      checks++;
      if (cyc != WS + 1) begin errors++; $display("[TB] FAIL write_latency: got %0d expected %0d", cyc, WS + 1); end
      end_cmd();
      ref_mem[idx(a)] = d;
      c = $urandom_range(0, 1) ? CMD_FETCH : CMD_READ;
      run_cmd(c, a, 32'h0, cyc, v);
      checks++;
      if (v !== ref_mem[idx(a)] || cyc != WS + 1)
        begin errors++; $display("[TB] FAIL read_back addr %h: got %h in %0d edges expected %h in %0d", a, v, cyc, ref_mem[idx(a)], WS + 1); end
      end_cmd();
    end
  endtask

  task automatic test_abort();
    int cyc;
    int seen;
    logic [31:0] v, prior;
    prior = $urandom & 32'h7FFF_FFFF;
    do_write(32'd9, prior);
    @(negedge clk);
    drive = CMD_WRITE; addr = 32'd9; tb_drive = 1'b1; tb_data = 32'hFFFF_FFFF;
    @(posedge clk);
    @(negedge clk);
    drive = CMD_NOP; tb_data = 32'h0;
    seen = 0;
    for (int i = 0; i < WS + 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (ready) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("[TB] FAIL abort_no_ready: got %0d ready cycles expected 0", seen); end
    run_cmd(CMD_READ, 32'd9, 32'h0, cyc, v);
    checks++;
    if (v !== prior) begin errors++; $display("[TB] FAIL abort_keeps_data: got %h expected %h", v, prior); end
    end_cmd();
  endtask

  task automatic test_hold();
    int cyc;
    logic [31:0] a, v;
    a = $urandom_range(16, DEPTH - 2) & ~32'h1;
    do_write(a, $urandom | 32'h1);
    run_cmd(CMD_READ, a, 32'h0, cyc, v);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (ready !== 1'b1 || bus !== ref_mem[idx(a)])
        begin errors++; $display("[TB] FAIL hold cycle %0d: ready %b bus %h expected 1 and %h", i, ready, bus, ref_mem[idx(a)]); end
    end
    addr = a ^ 32'h1; tb_drive = 1'b1; tb_data = 32'h0;
    @(posedge clk);
    @(negedge clk);
    drive = CMD_NOP;
    checks++;
    if (ready !== 1'b0 || bus !== 32'h0)
      begin errors++; $display("[TB] FAIL hold_addr_change: ready %b bus %h expected 0 and 00000000", ready, bus); end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset_mid_txn();
    int cyc;
    logic [31:0] v, d;
    d = $urandom | 32'h1;
    do_write(32'd11, d);
    run_cmd(CMD_READ, 32'd11, 32'h0, cyc, v);
    rst = 1'b1; tb_drive = 1'b1; tb_data = 32'h0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; drive = CMD_NOP;
    checks++;
    if (ready !== 1'b0 || bus !== 32'h0)
      begin errors++; $display("[TB] FAIL reset_in_ack: ready %b bus %h expected 0 and 00000000", ready, bus); end
    // A write interrupted by reset during WAIT never reaches the array.
    @(negedge clk);
    drive = CMD_WRITE; addr = 32'd11; tb_data = ~d;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; drive = CMD_NOP; tb_data = 32'h0;
    repeat (WS + 2) @(posedge clk);
    run_cmd(CMD_READ, 32'd11, 32'h0, cyc, v);
    checks++;
    if (v !== ref_mem[11]) begin errors++; $display("[TB] FAIL reset_persist: got %h expected %h", v, ref_mem[11]); end
    end_cmd();
  endtask

  task automatic test_range_and_reserved();
    int cyc;
    int seen;
    logic [31:0] v, d0, d5;
    d0 = $urandom | 32'h1;
    d5 = $urandom | 32'h1;
    do_write(32'd0, d0);
    do_write(32'd5, d5);
`ifdef MEM_RESP_FAULT_EN
    run_cmd(CMD_READ, 32'h0001_0000, 32'h0, cyc, v);
    checks++;
    if (cyc != WS + 1 || v !== FAULT_DATA || bus_fault !== 1'b1)
      begin errors++; $display("[TB] FAIL fault_read: %0d edges bus %h fault %b expected %0d, deadbeef, 1", cyc, v, bus_fault, WS + 1); end
    end_cmd();
    checks++;
    if (bus_fault !== 1'b0 || ready !== 1'b0)
      begin errors++; $display("[TB] FAIL fault_clear: fault %b ready %b expected 0 0", bus_fault, ready); end
    run_cmd(CMD_WRITE, DEPTH + 5, ~d5, cyc, v);
    checks++;
    if (bus_fault !== 1'b1) begin errors++; $display("[TB] FAIL fault_write: got %b expected 1", bus_fault); end
    end_cmd();
    run_cmd(CMD_IO_RD, 32'd3, 32'h0, cyc, v);
    checks++;
    if (cyc != WS + 1 || bus_fault !== 1'b1)
      begin errors++; $display("[TB] FAIL fault_reserved: %0d edges fault %b expected %0d and 1", cyc, bus_fault, WS + 1); end
    end_cmd();
`else
    run_cmd(CMD_READ, 32'h0001_0000, 32'h0, cyc, v);
    checks++;
    if (v !== ref_mem[0]) begin errors++; $display("[TB] FAIL wrap_read: got %h expected %h", v, ref_mem[0]); end
    end_cmd();
    do_write(DEPTH + 5, ~d5);
    @(negedge clk);
    drive = 3'b110; addr = 32'd5; tb_drive = 1'b1; tb_data = 32'h0;
    seen = 0;
    for (int i = 0; i < WS + 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (ready) seen++;
    end
    drive = CMD_NOP;
    checks++;
    if (seen != 0) begin errors++; $display("[TB] FAIL reserved_ignored: got %0d ready cycles expected 0", seen); end
`endif
    run_cmd(CMD_READ, 32'd5, 32'h0, cyc, v);
    checks++;
    if (v !== ref_mem[5]) begin errors++; $display("[TB] FAIL addr5_read: got %h expected %h", v, ref_mem[5]); end
    end_cmd();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_write_read();
    test_abort();
    test_hold();
    test_reset_mid_txn();
    test_range_and_reserved();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
